// File: rtl/dm_pipe.sv
// Word-organised data memory with byte/half/word access, self-clearing after reset,
// and a fixed-latency response pipeline that reports exceptions and echoes the PC.
`timescale 1ns/1ps
module dm_pipe #(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LAT         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [31:0] rsp_pc
);
    localparam int IDXW = $clog2(DEPTH_WORDS);

    typedef enum logic {INIT, RUN} state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_cnt;
    logic              r_ready;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              r_pVld  [LAT];
    logic [31:0]       r_pData [LAT];
    logic              r_pExc  [LAT];
    logic [31:0]       r_pPc   [LAT];

    logic              w_accept;
    logic [31:0]       w_offset;
    logic [31:0]       w_wordIdx;
    logic              w_oor;
    logic              w_misalign;
    logic              w_exc;
    logic [IDXW-1:0]   w_idx;
    logic [31:0]       w_old;
    logic [31:0]       w_merged;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [31:0]       w_loadData;

    assign w_accept   = req_valid && req_ready;
    assign w_offset   = req_addr - BASE_ADDR;
    assign w_wordIdx  = w_offset >> 2;
    assign w_oor      = (req_addr < BASE_ADDR) || (w_wordIdx >= 32'(DEPTH_WORDS));
    assign w_misalign = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                        ((req_size == 2'b01) && req_addr[0]);
    assign w_exc      = w_oor || w_misalign || (req_size == 2'b11);
    // Out-of-range requests still read a legal word so the array index never overflows.
    assign w_idx      = w_oor ? '0 : w_wordIdx[IDXW-1:0];
    assign w_old      = r_mem[w_idx];
    assign w_half     = req_addr[1] ? w_old[31:16] : w_old[15:0];
    assign w_byte     = w_old[8*req_addr[1:0] +: 8];

    always_comb begin
        w_merged = w_old;
        case (req_size)
            2'b00:   w_merged = req_wdata;
            2'b01:   w_merged[16*req_addr[1] +: 16] = req_wdata[15:0];
            2'b10:   w_merged[8*req_addr[1:0] +: 8] = req_wdata[7:0];
            default: w_merged = w_old;
        endcase
    end

    always_comb begin
        w_loadData = w_old;
        case (req_size)
            2'b01:   w_loadData = req_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            2'b10:   w_loadData = req_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            default: w_loadData = w_old;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_cnt == IDXW'(DEPTH_WORDS - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN:     r_ready <= 1'b1;
                default: r_state <= INIT;
            endcase
        end
    end

    // Reset blocks any write, including a request that happens to be accepted on the reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_accept && req_we && !w_exc) begin
                r_mem[w_idx] <= w_merged;
`ifndef SYNTHESIS
                $display("%d@%h: *%h <= %h", $time, req_pc, req_addr, w_merged);
`endif
            end
        end
    end

    // Idle stages carry zeros so the response fields are 0 whenever rsp_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_pVld[i]  <= 1'b0;
                r_pData[i] <= '0;
                r_pExc[i]  <= 1'b0;
                r_pPc[i]   <= '0;
            end
        end else begin
            r_pVld[0]  <= w_accept;
            r_pData[0] <= (w_accept && !req_we && !w_exc) ? w_loadData : 32'h0;
            r_pExc[0]  <= w_accept && w_exc;
            r_pPc[0]   <= w_accept ? req_pc : 32'h0;
            for (int i = 1; i < LAT; i++) begin
                r_pVld[i]  <= r_pVld[i-1];
                r_pData[i] <= r_pData[i-1];
                r_pExc[i]  <= r_pExc[i-1];
                r_pPc[i]   <= r_pPc[i-1];
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_pVld[LAT-1];
    assign rsp_rdata = r_pData[LAT-1];
    assign rsp_exc   = r_pExc[LAT-1];
    assign rsp_pc    = r_pPc[LAT-1];
endmodule

// File: tb/tb_dm_pipe.sv
// Scoreboard bench for dm_pipe: a byte-array memory model predicts each response,
// and an independent monitor checks data, exception, PC and exact response cycle.
`timescale 1ns/1ps
module tb_dm_pipe;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LATC  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [31:0] rsp_pc;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mMem [DEPTH*4];
    int          cyc = 0;
    int          nChecks = 0;
    int          nFail = 0;
    bit          monEn = 1'b0;

    dm_pipe #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LAT(LATC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc), .rsp_pc(rsp_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one request for a single cycle and records the response the memory rules predict.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          nb;
        logic [31:0] off;
        logic [31:0] v;
        logic        exc;
        exc = (size == 2'd3) || (addr < BASE) || (((addr - BASE) / 4) >= DEPTH) ||
              (size == 2'd0 && (addr % 4) != 0) || (size == 2'd1 && (addr % 2) != 0);
        nb  = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        v   = '0;
        if (!exc) begin
            off = addr - BASE;
            if (we) begin
                for (int k = 0; k < nb; k++) mMem[off + k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < nb; k++) v = v | (32'(mMem[off + k]) << (8*k));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            end
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = $urandom;
        e.rdata = v;
        e.exc   = exc;
        e.pc    = req_pc;
        e.due   = cyc + LATC;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idleCycle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Pulses reset while offering a store, then measures how long req_ready stays low.
    task automatic doReset();
        int n;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = BASE + 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        sb.delete();
        for (int k = 0; k < DEPTH*4; k++) mMem[k] = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1 || n > 100) break;
            n++;
        end
        req_valid = 1'b0;
        checkOutput("init_len", 32'(n), 32'(DEPTH));
        @(posedge clk);
        #1;
    endtask

    task automatic loadAllWords();
        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'(4*w), 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                    checkOutput("rsp_exc", 32'(rsp_exc), 32'(e.exc));
                    checkOutput("rsp_pc", rsp_pc, e.pc);
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                checkOutput("rsp_valid_known", 32'(rsp_valid), 32'h0);
                checkOutput("idle_fields", {rsp_rdata ^ rsp_pc, 31'h0, rsp_exc} == '0 ? 32'h0 : 32'h1, 32'h0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    checkOutput("missing_rsp", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        monEn = 1'b1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        doReset();
        loadAllWords();

        applyStimulus(1'b1, 2'b00, 1'b0, BASE + 32'h8, 32'h1122_3344);
        applyStimulus(1'b0, 2'b10, 1'b1, BASE + 32'hB, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, BASE + 32'h9, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b1, BASE + 32'hA, 32'h0);

        applyStimulus(1'b1, 2'b00, 1'b0, BASE + 32'h4, 32'hFFFF_0000);
        applyStimulus(1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'h0000_0080);
        applyStimulus(1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0);

        applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'h2, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, BASE + 32'h1, 32'hABCD);
        applyStimulus(1'b1, 2'b00, 1'b0, BASE + 32'(4*DEPTH), 32'h5555_5555);
        applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'(4*DEPTH), 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, BASE + 32'h0, 32'h7777_7777);

        applyStimulus(1'b1, 2'b00, 1'b0, BASE + 32'h0, 32'h0000_00A5);
        applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'h0, 32'h0);
        for (int w = 0; w < 4; w++) applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'(4*w), 32'h0);

        repeat (LATC + 2) idleCycle();
        applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'h8, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, BASE + 32'h4, 32'h0);
        doReset();
        loadAllWords();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idleCycle();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 4*DEPTH + 7)),
                              $urandom);
            end
        end
        loadAllWords();

        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            idleCycle();
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'h0);
        repeat (3) idleCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072: number of 32-bit words in the array (range 16..16384).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; must be word-aligned.
REQ-003 Parameter LAT, default 1: read/response latency in cycles after acceptance (range 1..4).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 word, 01 half, 10 byte, 11 reserved.
REQ-010 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data; half and byte use the low 16 and 8 bits.
REQ-013 req_pc  input  32  PC of the issuing instruction, for trace and response tagging.
REQ-014 rsp_valid  output  1  response for one accepted request.
REQ-015 rsp_rdata  output  32  extended load data; 0 for stores and exceptions.
REQ-016 rsp_exc  output  1  request was misaligned, out of range, or had reserved size.
REQ-017 rsp_pc  output  32  req_pc of the request being answered.

Function
REQ-018 States SHALL be INIT and RUN; reset forces INIT with clear counter 0.
REQ-019 In INIT, one word SHALL be zeroed per cycle at index = counter; after index DEPTH_WORDS-1 the state SHALL go to RUN, so INIT lasts exactly DEPTH_WORDS cycles.
REQ-020 req_ready SHALL be 0 in INIT and 1 in RUN; requests presented while req_ready=0 SHALL be dropped, not queued.
REQ-021 Acceptance SHALL be req_valid && req_ready; one request SHALL be accepted per cycle, fully pipelined.
REQ-022 Offset = req_addr - BASE_ADDR; index = offset[31:2]; a request is out of range if req_addr < BASE_ADDR or index >= DEPTH_WORDS.
REQ-023 Misaligned: size 00 with addr[1:0] != 0, or size 01 with addr[0] = 1.
REQ-024 An excepting request SHALL NOT modify memory and SHALL print no trace; its response SHALL have rsp_exc=1 and rsp_rdata=0.
REQ-025 A valid store SHALL update only the addressed bytes at the acceptance edge: half lane = addr[1], byte lane = addr[1:0], little-endian.
REQ-026 On every valid store, $display("%d@%h: *%h <= %h", $time, req_pc, req_addr, merged_word) SHALL be executed, where merged_word is the full 32-bit word after the merge.
REQ-027 A load SHALL sample the array as it was before that edge's write, so a load accepted the cycle after a store to the same word returns the new data.
REQ-028 Load extraction: half = word[16*addr[1] +: 16], byte = word[8*addr[1:0] +: 8], extended according to req_unsigned.
REQ-029 Every accepted request, store or load, SHALL produce exactly one response with rsp_valid=1 exactly LAT cycles after acceptance, in acceptance order.
REQ-030 rsp_rdata, rsp_exc and rsp_pc SHALL be 0 whenever rsp_valid=0.

Reset
REQ-031 On a reset edge, rsp_valid, rsp_rdata, rsp_exc, rsp_pc and req_ready SHALL be 0 from the next cycle, and all in-flight responses SHALL be discarded.
REQ-032 Reset asserted during INIT or RUN SHALL restart the clear from index 0.
REQ-033 A request accepted on the same edge that reset is sampled SHALL be ignored: no write and no trace.

Verification
REQ-034 Reset then idle with DEPTH_WORDS=16 -> req_ready=0 for exactly 16 cycles, then 1; a lw of every word returns 0.
REQ-035 sw 0x11223344 @0x8, then lbu @0xB, lb @0x9, lhu @0xA, with LAT=1 -> rsp_rdata is 0x11, 0x00000033, 0x1122 respectively, each one cycle after acceptance.
REQ-036 sw 0xFFFF0000 @0x4, sb 0x80 @0x4, lb @0x4 -> trace prints merged word ffff0080; rsp_rdata = 0xFFFFFF80.
REQ-037 lw @0x2, sh @0x1, and lw @(BASE_ADDR + 4*DEPTH_WORDS) -> each gets rsp_exc=1 and rsp_rdata=0; memory is unchanged and no trace is printed.
REQ-038 LAT=3 with back-to-back sw @0x0 of 0xA5, then lw @0x0 the next cycle -> two responses on consecutive cycles, 3 cycles after each acceptance, and the load returns 0xA5.
REQ-039 Reset pulsed while two loads are in flight -> no response ever appears for them, and INIT restarts (req_ready=0 for DEPTH_WORDS cycles).
